// File: rtl/cr_fifo_pkg.sv
// Shared types and helpers for the parametrised register-FIFO wrapper family.
package cr_fifo_pkg;

    typedef enum logic {
        CR_FIFO_SHOWAHEAD = 1'b0,
        CR_FIFO_REGRD     = 1'b1
    } cr_fifo_rd_mode_e;

    // Width needed to hold an occupancy count of 0..depth inclusive.
    function automatic int cr_fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cr_fifo_ptr_core.sv
// Register-array FIFO core: storage, wrapping pointers, occupancy count and full/empty.
module cr_fifo_ptr_core
    import cr_fifo_pkg::*;
#(
    parameter int DW    = 106,
    parameter int DEPTH = 16,
    parameter int CW    = cr_fifo_cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_wen,
    input  logic          i_ren,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_head,
    output logic          o_wacc,
    output logic          o_racc,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_count_nxt,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_wacc;
    logic          w_racc;
    logic [CW-1:0] w_count_nxt;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_racc      = i_ren & ~w_empty & ~i_clear;
    assign w_wacc      = i_wen & (~w_full | w_racc) & ~i_clear;
    assign w_count_nxt = i_clear ? '0 : (r_count + CW'(w_wacc) - CW'(w_racc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wacc) r_wptr <= ptr_inc(r_wptr);
            if (w_racc) r_rptr <= ptr_inc(r_rptr);
            r_count <= w_count_nxt;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wacc) r_mem[r_wptr] <= i_wdata;
    end

    assign o_head      = r_mem[r_rptr];
    assign o_wacc      = w_wacc;
    assign o_racc      = w_racc;
    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule

// File: rtl/cr_fifo_wrap_param.sv
// Parametrised FIFO wrapper: threshold flags, show-ahead or registered read, sticky errors,
// synchronous flush, BIMC pass-through and a tied-off ECC error.
module cr_fifo_wrap_param
    import cr_fifo_pkg::*;
#(
    parameter int DW        = 106,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 15,
    parameter int AEMPTY_TH = 1,
    parameter int RD_MODE   = 0,
    localparam int CW       = cr_fifo_cw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wdata,
    input  logic          wen,
    input  logic          ren,
    input  logic          clear,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic [CW-1:0] used_slots,
    output logic [CW-1:0] free_slots,
    output logic          overflow_err,
    output logic          underflow_err,
    input  logic          bimc_idat,
    input  logic          bimc_isync,
    input  logic          bimc_rst_n,
    output logic          bimc_odat,
    output logic          bimc_osync,
    output logic          ro_uncorrectable_ecc_error
);

    if (DEPTH < 2) begin : g_chk_depth
        $error("cr_fifo_wrap_param: DEPTH must be at least 2");
    end
    if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_chk_afull
        $error("cr_fifo_wrap_param: AFULL_TH must be in 1..DEPTH");
    end
    if (AEMPTY_TH < 0 || AEMPTY_TH >= DEPTH) begin : g_chk_aempty
        $error("cr_fifo_wrap_param: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [DW-1:0] w_head;
    logic          w_wacc;
    logic          w_racc;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_count_nxt;
    logic          r_afull;
    logic          r_aempty;
    logic          r_ovf;
    logic          r_unf;
    logic          w_unused;

    cr_fifo_ptr_core #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (clear),
        .i_wen       (wen),
        .i_ren       (ren),
        .i_wdata     (wdata),
        .o_head      (w_head),
        .o_wacc      (w_wacc),
        .o_racc      (w_racc),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // Flags are computed from the next count so they move in the same cycle as the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (clear) begin
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_afull  <= (w_count_nxt >= CW'(AFULL_TH));
            r_aempty <= (w_count_nxt <= CW'(AEMPTY_TH));
            if (wen & ~w_wacc) r_ovf <= 1'b1;
            if (ren & w_empty) r_unf <= 1'b1;
        end
    end

    if (RD_MODE == int'(CR_FIFO_REGRD)) begin : g_regrd
        logic [DW-1:0] r_rdata;
        logic          r_rvalid;

        // rdata keeps its last value; only rvalid marks a fresh read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_racc;
                if (w_racc) r_rdata <= w_head;
            end
        end

        assign rdata  = r_rdata;
        assign rvalid = r_rvalid;
    end else begin : g_showahead
        assign rdata  = w_head;
        assign rvalid = ~w_empty;
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign afull         = r_afull;
    assign aempty        = r_aempty;
    assign used_slots    = w_count;
    assign free_slots    = CW'(DEPTH) - w_count;
    assign overflow_err  = r_ovf;
    assign underflow_err = r_unf;

    // No memory macro behind this wrapper, so the BIMC chain is a wire and ECC never fires.
    assign bimc_odat                  = bimc_idat;
    assign bimc_osync                 = bimc_isync;
    assign ro_uncorrectable_ecc_error = 1'b0;
    assign w_unused                   = bimc_rst_n ^ w_racc;

endmodule

// File: tb/tb_cr_fifo_wrap_param.sv
// Bench for cr_fifo_wrap_param: three instances (8-deep show-ahead, 5-deep show-ahead,
// 8-deep registered read) share one stimulus stream and are checked against queue models.
module tb_cr_fifo_wrap_param;
    import cr_fifo_pkg::*;

    logic        clk;
    logic        rst;
    logic        wen;
    logic        ren;
    logic        clear;
    logic [15:0] wdata;
    logic        bimc_idat;
    logic        bimc_isync;
    logic        bimc_rst_n;

    logic [15:0] a_rdata, b_rdata, c_rdata;
    logic        a_rvalid, b_rvalid, c_rvalid;
    logic        a_full, b_full, c_full;
    logic        a_empty, b_empty, c_empty;
    logic        a_afull, b_afull, c_afull;
    logic        a_aempty, b_aempty, c_aempty;
    logic [3:0]  a_used, a_free, c_used, c_free;
    logic [2:0]  b_used, b_free;
    logic        a_ovf, b_ovf, c_ovf;
    logic        a_unf, b_unf, c_unf;
    logic        a_bodat, b_bodat, c_bodat;
    logic        a_bosync, b_bosync, c_bosync;
    logic        a_ecc, b_ecc, c_ecc;

    logic [15:0] exp_q[$];
    logic [15:0] exp_q5[$];
    logic [15:0] exp_qr[$];
    int          cnt8;
    int          cnt5;
    logic        exp_rv;
    int          n_chk;
    int          n_err;

    cr_fifo_wrap_param #(.DW(16), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .RD_MODE(0)) u_a (
        .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .ren(ren), .clear(clear),
        .rdata(a_rdata), .rvalid(a_rvalid), .full(a_full), .empty(a_empty),
        .afull(a_afull), .aempty(a_aempty), .used_slots(a_used), .free_slots(a_free),
        .overflow_err(a_ovf), .underflow_err(a_unf),
        .bimc_idat(bimc_idat), .bimc_isync(bimc_isync), .bimc_rst_n(bimc_rst_n),
        .bimc_odat(a_bodat), .bimc_osync(a_bosync), .ro_uncorrectable_ecc_error(a_ecc)
    );

    cr_fifo_wrap_param #(.DW(16), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1), .RD_MODE(0)) u_b (
        .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .ren(ren), .clear(clear),
        .rdata(b_rdata), .rvalid(b_rvalid), .full(b_full), .empty(b_empty),
        .afull(b_afull), .aempty(b_aempty), .used_slots(b_used), .free_slots(b_free),
        .overflow_err(b_ovf), .underflow_err(b_unf),
        .bimc_idat(bimc_idat), .bimc_isync(bimc_isync), .bimc_rst_n(bimc_rst_n),
        .bimc_odat(b_bodat), .bimc_osync(b_bosync), .ro_uncorrectable_ecc_error(b_ecc)
    );

    cr_fifo_wrap_param #(.DW(16), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .RD_MODE(1)) u_c (
        .clk(clk), .rst(rst), .wdata(wdata), .wen(wen), .ren(ren), .clear(clear),
        .rdata(c_rdata), .rvalid(c_rvalid), .full(c_full), .empty(c_empty),
        .afull(c_afull), .aempty(c_aempty), .used_slots(c_used), .free_slots(c_free),
        .overflow_err(c_ovf), .underflow_err(c_unf),
        .bimc_idat(bimc_idat), .bimc_isync(bimc_isync), .bimc_rst_n(bimc_rst_n),
        .bimc_odat(c_bodat), .bimc_osync(c_bosync), .ro_uncorrectable_ecc_error(c_ecc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change 2 time units after a rising edge; the model is advanced at issue time.
    task automatic step(input logic w, input logic r, input logic c, input logic [15:0] d);
        logic r8, w8, r5, w5;
        wen = w; ren = r; clear = c; wdata = d;
        r8 = 1'b0; w8 = 1'b0; r5 = 1'b0; w5 = 1'b0;
        if (c) begin
            exp_q.delete();
            exp_q5.delete();
            cnt8 = 0;
            cnt5 = 0;
        end else begin
            r8 = r && (cnt8 != 0);
            w8 = w && (cnt8 < 8 || r8);
            r5 = r && (cnt5 != 0);
            w5 = w && (cnt5 < 5 || r5);
            if (w8) begin
                exp_q.push_back(d);
                exp_qr.push_back(d);
            end
            if (w5) exp_q5.push_back(d);
            cnt8 = cnt8 + int'(w8) - int'(r8);
            cnt5 = cnt5 + int'(w5) - int'(r5);
        end
        @(posedge clk);
        #2;
        if (c) exp_qr.delete();
        exp_rv = r8;
        wen = 1'b0; ren = 1'b0; clear = 1'b0;
        chk("a_used", a_used, cnt8);
        chk("a_free", a_free, 8 - cnt8);
        chk("a_full", a_full, cnt8 == 8);
        chk("a_empty", a_empty, cnt8 == 0);
        chk("a_afull", a_afull, cnt8 >= 6);
        chk("a_aempty", a_aempty, cnt8 <= 2);
        chk("b_used", b_used, cnt5);
        chk("b_full", b_full, cnt5 == 5);
        chk("b_afull", b_afull, cnt5 >= 4);
        chk("b_aempty", b_aempty, cnt5 <= 1);
        chk("c_used", c_used, cnt8);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (!rst && ren && !clear && !a_empty) begin
            if (exp_q.size() == 0) chk("a_rd_unexpected", 1, 0);
            else chk("a_rdata", a_rdata, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("b_used_plus_free", 32'(b_used) + 32'(b_free), 5);
            if (ren && !clear && !b_empty) begin
                if (exp_q5.size() == 0) chk("b_rd_unexpected", 1, 0);
                else chk("b_rdata", b_rdata, exp_q5.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("c_rvalid", c_rvalid, exp_rv);
            if (c_rvalid) begin
                if (exp_qr.size() == 0) chk("c_rd_unexpected", 1, 0);
                else chk("c_rdata", c_rdata, exp_qr.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_chk = 0; n_err = 0; cnt8 = 0; cnt5 = 0; exp_rv = 1'b0;
        rst = 1'b1; wen = 1'b0; ren = 1'b0; clear = 1'b0; wdata = '0;
        bimc_idat = 1'b1; bimc_isync = 1'b0; bimc_rst_n = 1'b1;

        #3;
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_aempty", a_aempty, 1);
        chk("rst_afull", a_afull, 0);
        chk("rst_used", a_used, 0);
        chk("rst_free", a_free, 8);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_unf", a_unf, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("bimc_odat", a_bodat, 1);
        chk("bimc_osync", a_bosync, 0);
        chk("ecc_zero", a_ecc, 0);
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;

        // Fill: aempty falls at 3, afull rises at 6, full at 8.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(i));
            chk("fill_aempty", a_aempty, (i <= 2) ? 1 : 0);
            chk("fill_afull", a_afull, (i >= 6) ? 1 : 0);
        end
        chk("fill_full", a_full, 1);
        chk("fill_free", a_free, 0);

        // Full: simultaneous write and read both accepted; lone write overflows.
        step(1'b1, 1'b1, 1'b0, 16'h0009);
        chk("full_wr_rd_used", a_used, 8);
        chk("full_wr_rd_ovf", a_ovf, 0);
        step(1'b1, 1'b0, 1'b0, 16'h00AA);
        chk("ovf_set", a_ovf, 1);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("ovf_sticky", a_ovf, 1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("drained_empty", a_empty, 1);

        // Empty: lone read underflows; write+read accepts only the write.
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("unf_set", a_unf, 1);
        chk("unf_used", a_used, 0);
        step(1'b1, 1'b1, 1'b0, 16'h0033);
        chk("empty_wr_rd_used", a_used, 1);
        chk("empty_wr_rd_unf", a_unf, 1);
        step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Mid-stream flush with a write pending.
        step(1'b1, 1'b0, 1'b0, 16'h0061);
        step(1'b1, 1'b0, 1'b0, 16'h0062);
        step(1'b1, 1'b0, 1'b0, 16'h0063);
        step(1'b1, 1'b0, 1'b1, 16'h0064);
        chk("clr_used", a_used, 0);
        chk("clr_empty", a_empty, 1);
        chk("clr_aempty", a_aempty, 1);
        chk("clr_ovf", a_ovf, 0);
        chk("clr_unf", a_unf, 0);
        chk("clr_b_ovf", b_ovf, 0);
        chk("clr_c_rvalid", c_rvalid, 0);
        step(1'b1, 1'b0, 1'b0, 16'h0070);
        step(1'b0, 1'b1, 1'b0, 16'h0000);

        // Registered read latency.
        step(1'b1, 1'b0, 1'b0, 16'hA5A5);
        chk("regrd_idle_rvalid", c_rvalid, 0);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("regrd_rvalid", c_rvalid, 1);
        chk("regrd_rdata", c_rdata, 16'hA5A5);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("regrd_rvalid_drop", c_rvalid, 0);
        chk("regrd_rdata_hold", c_rdata, 16'hA5A5);

        // Random interleaved traffic; the 5-deep instance exercises non-power-of-two wrap.
        for (int i = 0; i < 50; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                 16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("rand_b_empty", b_empty, 1);

        bimc_idat = 1'b0; bimc_isync = 1'b1; #1;
        chk("bimc_odat_flip", a_bodat, 0);
        chk("bimc_osync_flip", a_bosync, 1);

        // Async reset in the middle of an overflowing write burst.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 16'(16'h0100 + i));
        chk("pre_rst_ovf", a_ovf, 1);
        wen = 1'b1; wdata = 16'h0BAD;
        rst = 1'b1;
        #1;
        chk("arst_used", a_used, 0);
        chk("arst_empty", a_empty, 1);
        chk("arst_full", a_full, 0);
        chk("arst_aempty", a_aempty, 1);
        chk("arst_afull", a_afull, 0);
        chk("arst_ovf", a_ovf, 0);
        chk("arst_c_rdata", c_rdata, 0);
        chk("arst_b_used", b_used, 0);
        exp_q.delete(); exp_q5.delete(); exp_qr.delete();
        cnt8 = 0; cnt5 = 0; exp_rv = 1'b0; wen = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 16'h0777);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
